// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file, three registered read ports,
// one write-back port and a per-register busy scoreboard.
// Optional debug ports are enabled by defining REGFILE_DBG_EN.
module regfile_sb #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    input  logic [ADDR_W-1:0] rd_addr_c,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic [DATA_W-1:0] rd_data_c,
    output logic              busy_a,
    output logic              busy_b,
    output logic              busy_c,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
`ifdef REGFILE_DBG_EN
    input  logic [ADDR_W-1:0]      dbg_addr,
    output logic [DATA_W-1:0]      dbg_data,
    output logic [(1<<ADDR_W)-1:0] dbg_busy,
`endif
    output logic              rsv_err
);

    localparam int NREGS = 1 << ADDR_W;
    localparam int NPORT = 3;

    localparam bit ZR = (ZERO_REG != 0);
    localparam bit BP = (BYPASS != 0);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [NREGS-1:0]  busy_q;
    logic [NREGS-1:0]  busy_d;

    logic [ADDR_W-1:0] rd_addr [NPORT];
    logic [DATA_W-1:0] rd_q    [NPORT];
    logic [DATA_W-1:0] rd_d    [NPORT];
    logic [NPORT-1:0]  bsy_q;
    logic [NPORT-1:0]  bsy_d;

    logic rsv_err_q;
    logic rsv_err_d;
    logic wr_ok;
    logic rsv_ok;

    assign rd_addr[0] = rd_addr_a;
    assign rd_addr[1] = rd_addr_b;
    assign rd_addr[2] = rd_addr_c;

    assign rd_data_a = rd_q[0];
    assign rd_data_b = rd_q[1];
    assign rd_data_c = rd_q[2];
    assign busy_a    = bsy_q[0];
    assign busy_b    = bsy_q[1];
    assign busy_c    = bsy_q[2];
    assign rsv_err   = rsv_err_q;

    // Qualify write/reserve strobes: register 0 is immutable when hardwired.
    always_comb begin
        wr_ok  = wr_en  && !(ZR && (wr_addr == '0));
        rsv_ok = rsv_en && !(ZR && (rsv_addr == '0));
    end

    // Next-state array contents and scoreboard; reserve overrides write clear.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        busy_d = busy_q;
        if (wr_ok) begin
            regs_d[wr_addr] = wr_data;
            busy_d[wr_addr] = 1'b0;
        end
        if (rsv_ok) begin
            busy_d[rsv_addr] = 1'b1;
        end
    end

    // Per-port read select and busy flag, sampled into the output flops.
    always_comb begin
        for (int p = 0; p < NPORT; p++) begin
            rd_d[p]  = regs_q[rd_addr[p]];
            bsy_d[p] = busy_d[rd_addr[p]];
            if (BP && wr_en && (wr_addr == rd_addr[p])) begin
                rd_d[p] = wr_data;
            end
            if (!BP && wr_ok && (wr_addr == rd_addr[p])) begin
                bsy_d[p] = 1'b1;
            end
            if (ZR && (rd_addr[p] == '0)) begin
                rd_d[p] = '0;
            end
        end
    end

    // A reserve collides only if the target stays busy through this edge.
    always_comb begin
        rsv_err_d = rsv_en && busy_q[rsv_addr]
                    && !(wr_en && (wr_addr == rsv_addr));
    end

    // Storage, scoreboard and registered outputs; reset clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            for (int p = 0; p < NPORT; p++) begin
                rd_q[p] <= '0;
            end
            busy_q    <= '0;
            bsy_q     <= '0;
            rsv_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            for (int p = 0; p < NPORT; p++) begin
                rd_q[p] <= rd_d[p];
            end
            busy_q    <= busy_d;
            bsy_q     <= bsy_d;
            rsv_err_q <= rsv_err_d;
        end
    end

`ifdef REGFILE_DBG_EN
    // Debug view: raw storage (no bypass) and the full scoreboard.
    always_comb begin
        dbg_data = regs_q[dbg_addr];
        if (ZR && (dbg_addr == '0)) begin
            dbg_data = '0;
        end
        dbg_busy = busy_q;
    end
`endif

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the processor's 16x16 register file.
- Three read ports: two sources (A, B) and one destination-operand (C).
- One write-back port, and a per-register busy scoreboard so the multi-cycle control unit can stall on pending writes.
- All activity on the rising clock edge; registered reads with optional write-through bypass replace the old delayed-read scheme.

Parameters:
- DATA_W, 16, register width in bits
- ADDR_W, 4, address width; NREGS = 2**ADDR_W registers
- BYPASS, 1, 1 = same-cycle write data forwarded to read outputs; 0 = reads return pre-write contents
- ZERO_REG, 0, 1 = register 0 hardwired to zero and never busy

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- rd_addr_a  in  ADDR_W  read address A
- rd_addr_b  in  ADDR_W  read address B
- rd_addr_c  in  ADDR_W  read address C
- rd_data_a  out  DATA_W  registered read data A
- rd_data_b  out  DATA_W  registered read data B
- rd_data_c  out  DATA_W  registered read data C
- busy_a  out  1  registered busy flag for rd_addr_a
- busy_b  out  1  registered busy flag for rd_addr_b
- busy_c  out  1  registered busy flag for rd_addr_c
- wr_en  in  1  write-back strobe
- wr_addr  in  ADDR_W  write-back address
- wr_data  in  DATA_W  write-back data
- rsv_en  in  1  reserve destination (set busy)
- rsv_addr  in  ADDR_W  register to reserve
- rsv_err  out  1  one-cycle pulse: reserve hit an already-busy register

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset state (rst_n low, asynchronous): all registers = 0, all busy bits = 0, rd_data_* = 0, busy_* = 0, rsv_err = 0.
- Reset mid-operation discards pending writes and reservations immediately.
- Write: on the rising edge with wr_en=1, reg[wr_addr] <= wr_data and busy[wr_addr] is cleared.
- Write to register 0 when ZERO_REG=1: ignored; register 0 stays 0.
- Read latency is 1 cycle. Each port independently samples its address at the edge and rd_data_x <= the selected value:
  - BYPASS=1 and wr_en=1 and wr_addr==rd_addr_x: wr_data.
  - Otherwise: reg[rd_addr_x] before this edge's write.
  - ZERO_REG=1 and rd_addr_x==0: 0 (forced regardless of bypass).
- Reserve: on the edge with rsv_en=1, busy[rsv_addr] <= 1.
  - Ignored for address 0 when ZERO_REG=1.
- Reserve and write to the same address on the same edge: reserve wins and busy stays 1 (the new producer supersedes the completed one). The data write still occurs.
- busy_next is the busy vector after this edge's write and reserve updates.
- busy_x registered value:
  - BYPASS=1: busy_x <= busy_next[rd_addr_x].
  - BYPASS=0: busy_x <= busy_next[rd_addr_x] | (wr_en && wr_addr==rd_addr_x && addr writable), so a stale read is always flagged.
- rsv_err <= rsv_en && busy[rsv_addr] && !(wr_en && wr_addr==rsv_addr), i.e. busy and not being cleared this edge. It is high for exactly one cycle per offending reserve.
- No arithmetic; all widths follow the parameters; addresses are never out of range because NREGS = 2**ADDR_W.
- Reads are not gated by busy; the control unit decides whether to stall.

Optional Feature:
- Macro: REGFILE_DBG_EN.
- When defined, the block adds:
  - input dbg_addr [ADDR_W].
  - output dbg_data [DATA_W]: combinational reg[dbg_addr], no bypass, 0 for register 0 when ZERO_REG=1.
  - output dbg_busy [NREGS]: the full busy vector.
- These are used by the display and test harness in place of simulation-delay tricks.
- When not defined, none of these ports exist and behaviour is otherwise identical.

Test Plan:
1. Reset, then read all addresses on ports A/B/C -> every rd_data = 0x0000 and every busy = 0 one cycle after each address is applied.
2. BYPASS=1: write wr_addr=5, wr_data=0x0014 while rd_addr_a=5 on the same edge -> rd_data_a=0x0014 the next cycle. Repeat with BYPASS=0 -> rd_data_a=0x0000 and busy_a=1, then 0x0014 and busy_a=0 the following cycle.
3. Reserve register 9 -> busy_b=1 while rd_addr_b=9. Then write 9 with 0x5878 -> the next cycle busy_b=0 and rd_data_b=0x5878.
4. Reserve 3 and write 3 (data 0xff49) on the same edge -> register 3 holds 0xff49, busy stays 1, rsv_err=0. A second reserve of 3 on the next edge -> rsv_err=1 for one cycle.
5. ZERO_REG=1: write 0 with 0xc61b and reserve 0 -> reads of address 0 return 0x0000 with busy=0; rsv_err never asserts for address 0.
6. Write 0xb7a1 to register 7 and reserve 7, then pulse rst_n low mid-cycle -> outputs go to 0 immediately without a clock edge; after release, register 7 reads 0x0000 and is not busy.
